// File: rtl/bus_port_fifo.sv
// bus_port_fifo: per-port transmit FIFO feeding the bus generator/arbiter.
// Circular buffer with first-word-fall-through head, occupancy reporting,
// an almost-full warning and sticky overflow/underflow error flags.
module bus_port_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 16,
    parameter int af_lvl  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       pop,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int cnt_w = $clog2(depth + 1);
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

    localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);
    localparam logic [cnt_w-1:0] af_c    = cnt_w'(af_lvl);
    localparam logic [ptr_w-1:0] last_c  = ptr_w'(depth - 1);

    // Storage; contents are never cleared, the head is masked while empty.
    logic [pckg_sz-1:0] mem [depth];

    logic [ptr_w-1:0] wp_reg, wp_next;
    logic [ptr_w-1:0] rp_reg, rp_next;
    logic [cnt_w-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic             push_ok;
    logic             pop_ok;
    logic [pckg_sz-1:0] head;

    // Status decoded from registered state only, never from push/pop.
    assign pndng       = (count_reg != '0);
    assign full        = (count_reg == depth_c);
    assign almost_full = (count_reg >= af_c);
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

    // A pop is only honoured when the bus already sees valid data; a push
    // into a full FIFO is honoured only if a pop frees a slot at the same edge.
    assign pop_ok  = pop && pndng;
    assign push_ok = push && (!full || pop);

    assign head = mem[rp_reg];

    // Head entry forced to zero while empty so stale contents never leak.
    generate
        for (genvar gi = 0; gi < pckg_sz; gi++) begin : g_dpop
            assign D_pop[gi] = pndng & head[gi];
        end
    endgenerate

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wp_next        = wp_reg;
        rp_next        = rp_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (push_ok) begin
            wp_next = (wp_reg == last_c) ? '0 : wp_reg + 1'b1;
        end else if (push) begin
            overflow_next = 1'b1;
        end

        if (pop_ok) begin
            rp_next = (rp_reg == last_c) ? '0 : rp_reg + 1'b1;
        end else if (pop) begin
            underflow_next = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Control state registers; reset wins over any concurrent push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_reg        <= '0;
            rp_reg        <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wp_reg        <= wp_next;
            rp_reg        <= rp_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Data array write; blocked during reset so a dropped cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wp_reg] <= D_push;
        end
    end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Testbench for bus_port_fifo: directed scenarios plus randomized traffic,
// each checked against a queue-based behavioural model of the FIFO rules.
module tb_bus_port_fifo;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (depth 16, almost-full at 12)
    logic        rst16, push16, pop16;
    logic [15:0] dpush16, dpop16;
    logic        pndng16, full16, af16, ovf16, unf16;
    logic [4:0]  cnt16;

    // Small non-power-of-two instance (depth 5, almost-full at 3)
    logic        rst5, push5, pop5;
    logic [15:0] dpush5, dpop5;
    logic        pndng5, full5, af5, ovf5, unf5;
    logic [2:0]  cnt5;

    bus_port_fifo dut (
        .clk(clk), .reset(rst16), .push(push16), .D_push(dpush16), .pop(pop16),
        .pndng(pndng16), .D_pop(dpop16), .full(full16), .almost_full(af16),
        .count(cnt16), .overflow(ovf16), .underflow(unf16)
    );

    bus_port_fifo #(.pckg_sz(16), .depth(5), .af_lvl(3)) dut5 (
        .clk(clk), .reset(rst5), .push(push5), .D_push(dpush5), .pop(pop5),
        .pndng(pndng5), .D_pop(dpop5), .full(full5), .almost_full(af5),
        .count(cnt5), .overflow(ovf5), .underflow(unf5)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural models: an ordered queue plus sticky flags
    logic [15:0] q16[$];
    logic        m16_ovf, m16_unf;
    logic [15:0] q5[$];
    logic        m5_ovf, m5_unf;

    // One clock of stimulus on the depth-16 instance, then model update
    task automatic step16(input logic r, input logic p, input logic [15:0] d, input logic po);
        int n;
        bit pop_acc, push_acc;
        rst16 = r; push16 = p; dpush16 = d; pop16 = po;
        @(posedge clk);
        #1;
        if (r) begin
            q16.delete(); m16_ovf = 0; m16_unf = 0;
        end else begin
            n        = q16.size();
            pop_acc  = po && (n > 0);
            push_acc = p && ((n < 16) || po);
            if (po && !pop_acc) m16_unf = 1;
            if (p && !push_acc) m16_ovf = 1;
            if (pop_acc) void'(q16.pop_front());
            if (push_acc) q16.push_back(d);
        end
        rst16 = 0; push16 = 0; pop16 = 0;
    endtask

    // One clock of stimulus on the depth-5 instance, then model update
    task automatic step5(input logic r, input logic p, input logic [15:0] d, input logic po);
        int n;
        bit pop_acc, push_acc;
        rst5 = r; push5 = p; dpush5 = d; pop5 = po;
        @(posedge clk);
        #1;
        if (r) begin
            q5.delete(); m5_ovf = 0; m5_unf = 0;
        end else begin
            n        = q5.size();
            pop_acc  = po && (n > 0);
            push_acc = p && ((n < 5) || po);
            if (po && !pop_acc) m5_unf = 1;
            if (p && !push_acc) m5_ovf = 1;
            if (pop_acc) void'(q5.pop_front());
            if (push_acc) q5.push_back(d);
        end
        rst5 = 0; push5 = 0; pop5 = 0;
    endtask

    task automatic test_reset();
        logic [24:0] got, exp;
        step16(1, 0, 16'h0, 0);
        step16(1, 0, 16'h0, 0);
        got = {pndng16, dpop16, full16, af16, cnt16, ovf16, unf16};
        exp = '0;
        n_checks++;
        if (got !== exp) $display("FAIL reset_state got %h want %h", got, exp);
        else n_pass++;
        $display("reset: outputs %h", got);
    endtask

    task automatic test_single_entry();
        step16(0, 1, 16'hA5A5, 0);
        n_checks++;
        if ({pndng16, dpop16, cnt16} !== {1'b1, 16'hA5A5, 5'd1})
            $display("FAIL single_push got pndng=%b d=%h cnt=%0d want 1 a5a5 1", pndng16, dpop16, cnt16);
        else n_pass++;
        $display("single: push a5a5 -> pndng=%b D_pop=%h count=%0d", pndng16, dpop16, cnt16);
        step16(0, 0, 16'h0, 1);
        n_checks++;
        if ({pndng16, dpop16, cnt16} !== {1'b0, 16'h0, 5'd0})
            $display("FAIL single_pop got pndng=%b d=%h cnt=%0d want 0 0000 0", pndng16, dpop16, cnt16);
        else n_pass++;
        $display("single: pop -> pndng=%b D_pop=%h count=%0d", pndng16, dpop16, cnt16);
    endtask

    task automatic test_fill_overflow();
        step16(1, 0, 16'h0, 0);
        for (int i = 1; i <= 16; i++) begin
            step16(0, 1, 16'(i), 0);
            n_checks++;
            if ({af16, cnt16} !== {(i >= 12), 5'(i)})
                $display("FAIL fill_af push=%0d got af=%b cnt=%0d want af=%b cnt=%0d", i, af16, cnt16, (i >= 12), i);
            else n_pass++;
            $display("fill: push %04h count=%0d almost_full=%b", i, cnt16, af16);
        end
        n_checks++;
        if (full16 !== 1'b1) $display("FAIL fill_full got %b want 1", full16);
        else n_pass++;
        step16(0, 1, 16'hDEAD, 0);
        n_checks++;
        if ({ovf16, cnt16, full16} !== {1'b1, 5'd16, 1'b1})
            $display("FAIL overflow got ovf=%b cnt=%0d full=%b want 1 16 1", ovf16, cnt16, full16);
        else n_pass++;
        $display("fill: push dead dropped, overflow=%b count=%0d", ovf16, cnt16);
        for (int i = 1; i <= 16; i++) begin
            n_checks++;
            if ({pndng16, dpop16} !== {1'b1, 16'(i)})
                $display("FAIL drain_order idx=%0d got %h want %h", i, dpop16, 16'(i));
            else n_pass++;
            $display("drain: D_pop=%04h", dpop16);
            step16(0, 0, 16'h0, 1);
        end
        n_checks++;
        if ({pndng16, dpop16, cnt16} !== {1'b0, 16'h0, 5'd0})
            $display("FAIL drain_empty got pndng=%b d=%h cnt=%0d want 0 0 0", pndng16, dpop16, cnt16);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] last;
        step16(1, 0, 16'h0, 0);
        for (int i = 0; i < 16; i++) step16(0, 1, 16'($urandom), 0);
        step16(0, 1, 16'h1234, 1);
        n_checks++;
        if ({cnt16, ovf16, full16} !== {5'd16, 1'b0, 1'b1})
            $display("FAIL full_pushpop got cnt=%0d ovf=%b full=%b want 16 0 1", cnt16, ovf16, full16);
        else n_pass++;
        $display("full push+pop: count=%0d overflow=%b", cnt16, ovf16);
        last = 16'h0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dpop16 !== q16[0]) $display("FAIL full_drain idx=%0d got %h want %h", i, dpop16, q16[0]);
            else n_pass++;
            last = dpop16;
            step16(0, 0, 16'h0, 1);
        end
        n_checks++;
        if (last !== 16'h1234) $display("FAIL full_last got %h want 1234", last);
        else n_pass++;
        $display("full push+pop: last drained %04h", last);
    endtask

    task automatic test_empty_push_pop();
        step16(1, 0, 16'h0, 0);
        step16(0, 1, 16'h00FF, 1);
        n_checks++;
        if ({cnt16, dpop16, unf16, pndng16} !== {5'd1, 16'h00FF, 1'b1, 1'b1})
            $display("FAIL empty_pushpop got cnt=%0d d=%h unf=%b want 1 00ff 1", cnt16, dpop16, unf16);
        else n_pass++;
        $display("empty push+pop: count=%0d D_pop=%04h underflow=%b", cnt16, dpop16, unf16);
    endtask

    task automatic test_wrap_depth5();
        logic [15:0] d;
        step5(1, 0, 16'h0, 0);
        step5(0, 1, 16'($urandom), 0);
        step5(0, 1, 16'($urandom), 0);
        for (int i = 0; i < 15; i++) begin
            d = 16'($urandom);
            n_checks++;
            if ({pndng5, dpop5, cnt5} !== {(q5.size() > 0), (q5.size() > 0) ? q5[0] : 16'h0, 3'(q5.size())} || cnt5 > 3'd5)
                $display("FAIL wrap5 i=%0d got d=%h cnt=%0d want d=%h cnt=%0d", i, dpop5, cnt5,
                         (q5.size() > 0) ? q5[0] : 16'h0, q5.size());
            else n_pass++;
            $display("wrap5: head=%04h count=%0d push=%04h", dpop5, cnt5, d);
            if (i < 13) step5(0, 1, d, 1);
            else step5(0, 0, 16'h0, 1);
        end
        n_checks++;
        if ({pndng5, dpop5, cnt5, ovf5, unf5} !== {1'b0, 16'h0, 3'd0, 1'b0, 1'b0})
            $display("FAIL wrap5_end got pndng=%b d=%h cnt=%0d ovf=%b unf=%b want all 0", pndng5, dpop5, cnt5, ovf5, unf5);
        else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [24:0] got, exp;
        logic        r, p, po;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            step16(r, p, 16'($urandom), po);
            exp = {(q16.size() > 0), (q16.size() > 0) ? q16[0] : 16'h0, (q16.size() == 16),
                   (q16.size() >= 12), 5'(q16.size()), m16_ovf, m16_unf};
            got = {pndng16, dpop16, full16, af16, cnt16, ovf16, unf16};
            n_checks++;
            if (got !== exp) $display("FAIL random cyc=%0d got %h want %h", i, got, exp);
            else n_pass++;
            $display("random: rst=%b push=%b pop=%b -> %h", r, p, po, got);
        end
    endtask

    task automatic test_reset_mid();
        step16(1, 0, 16'h0, 0);
        step16(0, 0, 16'h0, 1);
        for (int i = 0; i < 7; i++) step16(0, 1, 16'($urandom), 0);
        n_checks++;
        if ({cnt16, unf16} !== {5'd7, 1'b1})
            $display("FAIL reset_mid_pre got cnt=%0d unf=%b want 7 1", cnt16, unf16);
        else n_pass++;
        step16(1, 1, 16'hBEEF, 1);
        n_checks++;
        if ({cnt16, pndng16, dpop16, ovf16, unf16} !== {5'd0, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset_mid got cnt=%0d pndng=%b d=%h ovf=%b unf=%b want all 0",
                     cnt16, pndng16, dpop16, ovf16, unf16);
        else n_pass++;
        $display("reset mid: count=%0d pndng=%b D_pop=%04h", cnt16, pndng16, dpop16);
        step16(0, 1, 16'h4321, 0);
        n_checks++;
        if ({cnt16, dpop16} !== {5'd1, 16'h4321})
            $display("FAIL reset_resume got cnt=%0d d=%h want 1 4321", cnt16, dpop16);
        else n_pass++;
    endtask

    initial begin
        rst16 = 1; push16 = 0; pop16 = 0; dpush16 = '0;
        rst5  = 1; push5  = 0; pop5  = 0; dpush5  = '0;
        m16_ovf = 0; m16_unf = 0; m5_ovf = 0; m5_unf = 0;
        test_reset();
        test_single_entry();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap_depth5();
        test_random_traffic();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_port_fifo.md
# bus_port_fifo

Per-port transmit FIFO that sits directly upstream of the bus generator/arbiter `bs_gnrtr_n_rbtr`, one instance per driver port. It buffers packets written by the port-side agent and presents them to the bus through the `pndng` / `pop` / `D_pop` handshake. The head entry is presented first-word-fall-through. The block also reports occupancy, an almost-full warning, and sticky overflow/underflow error flags.

## Interface
- `pckg_sz`, 16, packet width in bits; matches the bus `pckg_sz`.
- `depth`, 16, number of entries; any integer ≥ 2, need not be a power of two.
- `af_lvl`, 12, almost-full threshold; 1 ≤ `af_lvl` ≤ `depth`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `push`  in  1  agent write strobe.
- `D_push`  in  `pckg_sz`  agent write data, sampled when `push` = 1.
- `pop`  in  1  bus read strobe; dequeues the head entry.
- `pndng`  out  1  FIFO non-empty; `D_pop` is valid.
- `D_pop`  out  `pckg_sz`  head entry.
- `full`  out  1  count == `depth`.
- `almost_full`  out  1  count ≥ `af_lvl`.
- `count`  out  `$clog2(depth+1)`  current occupancy.
- `overflow`  out  1  sticky; set when a push is dropped.
- `underflow`  out  1  sticky; set when a pop arrives while empty.

## Operation
- Storage is a circular buffer `mem[depth]` with write pointer `wp`, read pointer `rp`, and occupancy counter `count`.
- Each pointer wraps from `depth-1` to 0. The wrap is an explicit compare, not a power-of-two mask.
- A push is accepted when `push` = 1 and either `full` = 0, or `full` = 1 and `pop` = 1 in the same cycle. On acceptance: `mem[wp]` ← `D_push`, then `wp` advances.
- A push that is not accepted drops its data, leaves `wp` and `count` unchanged, and sets `overflow`.
- A pop is accepted when `pop` = 1 and `pndng` = 1. On acceptance `rp` advances.
- A pop while empty is ignored and sets `underflow`. This includes the case of a simultaneous push into an empty FIFO: that push is accepted and the pop is ignored, so the bus can never pop data it has not yet seen.
- Count update: +1 on accepted push only, −1 on accepted pop only, unchanged when both or neither are accepted.
- `pndng` = (`count` != 0).
- `D_pop` = `mem[rp]` when `pndng` = 1, otherwise all zeros.
- `overflow` and `underflow` stay set until `reset`.
- Reset clears `wp`, `rp`, `count`, `overflow` and `underflow`. Reset has priority over a concurrent push or pop.
- Contents of `mem` are not cleared by reset. They are unobservable because `D_pop` is forced to 0 while empty.

## Timing
- Reset values: `pndng` = 0, `D_pop` = 0, `full` = 0, `almost_full` = 0, `count` = 0, `overflow` = 0, `underflow` = 0.
  - Exception: if `af_lvl` ≤ 0 is ever parameterised, that is illegal; no reset behaviour is defined for it.
- Push-to-visible latency: a push accepted at edge N makes `pndng` = 1 and `D_pop` valid in the cycle after edge N (1 cycle). There is no extra pipeline stage.
- Pop: an accepted pop at edge N presents the next entry on `D_pop` after edge N, or drives 0 with `pndng` = 0 if that was the last entry.
  - The bus may assert `pop` in consecutive cycles and drain one entry per cycle.
- `full`, `almost_full`, `count` and `pndng` are decoded combinationally from registered state. None of them depends combinationally on `push` or `pop`.
- Sticky flags assert the cycle after the offending edge.
- Reset asserted mid-burst: at the next edge the FIFO is empty regardless of `push`/`pop`. Operation resumes normally on the first edge with `reset` = 0.

## Test plan
- **Reset then single entry:** reset for 2 cycles, then push 0xA5A5 once.
  - Next cycle: `pndng` = 1, `D_pop` = 0xA5A5, `count` = 1.
  - Pop once: `pndng` = 0, `D_pop` = 0, `count` = 0.
- **Fill and overflow (defaults):**
  - Push 0x0001..0x0010: `full` = 1, `count` = 16, and `almost_full` first asserts after the 12th push.
  - 17th push of 0xDEAD: dropped, `overflow` = 1.
  - Drain 16 pops: values 0x0001..0x0010 in order, with 0xDEAD absent.
- **Simultaneous push and pop when full:** with 16 entries, push 0x1234 and pop in the same cycle.
  - `count` stays 16, `overflow` stays 0, and the last value drained is 0x1234.
- **Simultaneous push and pop when empty:** push 0x00FF with `pop` = 1.
  - Result: `count` = 1, `D_pop` = 0x00FF, `underflow` = 1.
- **Wrap-around with `depth` = 5:** run 13 push/pop pairs offset by 2 entries.
  - Output sequence matches input sequence exactly; `count` never exceeds 5 and never goes below 0.
- **Reset mid-operation:** with 7 entries queued, assert `reset` concurrent with a push and a pop.
  - Next cycle: `count` = 0, `pndng` = 0, `D_pop` = 0, and both flags are 0.
